// File: rtl/layer_sequencer_pkg.sv
// Shared constants for the layer sequencer: state-code width and the named pipeline stages.
package layer_sequencer_pkg;

    localparam int unsigned STATE_LEN = 3;

    // Named stage codes; code 0 is the idle/home state.
    typedef enum logic [STATE_LEN-1:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CONV  = 3'd2,
        ST_POOL  = 3'd3,
        ST_ACT   = 3'd4,
        ST_STORE = 3'd5
    } state_e;

    localparam logic [STATE_LEN-1:0] IDLE  = ST_IDLE;
    localparam logic [STATE_LEN-1:0] FIRST = ST_LOAD;

endpackage

// File: rtl/layer_sequencer_stage_timer.sv
// Per-stage watchdog counter: counts enabled cycles since the last clear and flags the
// cycle in which the count sits at TIMEOUT-1 while still enabled.
module layer_sequencer_stage_timer #(
    parameter int unsigned WIDTH   = 11,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [WIDTH-1:0] LAST_CNT = WIDTH'(TIMEOUT - 1);

    logic [WIDTH-1:0] r_count;

    // Stall counter; clear wins over enable so a stage entry always restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign expired = enable && (r_count == LAST_CNT);

endmodule

// File: rtl/layer_sequencer.sv
// Top-level pipeline sequencer: steps through NUM_STATES stages gated by run and stage_done,
// loops LOOP_FIRST..LOOP_LAST NUM_ITER times, and aborts a stalled stage via a watchdog.
module layer_sequencer
    import layer_sequencer_pkg::*;
#(
    parameter int unsigned NUM_STATES = 6,
    parameter int unsigned LOOP_FIRST = int'(ST_CONV),
    parameter int unsigned LOOP_LAST  = int'(ST_ACT),
    parameter int unsigned NUM_ITER   = 3,
    parameter int unsigned TIMEOUT    = 1024,
    localparam int unsigned ITER_LEN  = $clog2(NUM_ITER + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic                 start,
    input  logic                 set,
    input  logic [STATE_LEN-1:0] d,
    input  logic                 stage_done,
    output logic [STATE_LEN-1:0] q,
    output logic                 stage_start,
    output logic [ITER_LEN-1:0]  iter,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    localparam logic [STATE_LEN:0]   NUM_Q      = (STATE_LEN + 1)'(NUM_STATES);
    localparam logic [STATE_LEN-1:0] LAST_Q     = STATE_LEN'(NUM_STATES - 1);
    localparam logic [STATE_LEN-1:0] LOOP_F_Q   = STATE_LEN'(LOOP_FIRST);
    localparam logic [STATE_LEN-1:0] LOOP_L_Q   = STATE_LEN'(LOOP_LAST);
    localparam logic [ITER_LEN-1:0]  ITER_MAX   = ITER_LEN'(NUM_ITER - 1);
    localparam int unsigned          TIMER_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [STATE_LEN-1:0] r_q;
    logic [ITER_LEN-1:0]  r_iter;
    logic                 r_stage_start;
    logic                 r_done;
    logic                 r_error;

    logic [STATE_LEN-1:0] w_q_nxt;
    logic [ITER_LEN-1:0]  w_iter_nxt;
    logic                 w_error_nxt;
    logic                 w_enter;
    logic                 w_done_nxt;
    logic                 w_busy;
    logic                 w_timer_en;
    logic                 w_expired;

    assign w_busy     = (r_q != IDLE);
    assign w_timer_en = run && w_busy && !stage_done;

    if (TIMEOUT > 0) begin : g_wdog
        layer_sequencer_stage_timer #(
            .WIDTH   (TIMER_W),
            .TIMEOUT (TIMEOUT)
        ) u_stage_timer (
            .clk     (clk),
            .rst_n   (rst_n),
            .clear   (w_enter),
            .enable  (w_timer_en),
            .expired (w_expired)
        );
    end else begin : g_no_wdog
        assign w_expired = 1'b0;
    end

    // Next-state decode; priority is set, then watchdog expiry, then start/advance under run.
    always_comb begin
        w_q_nxt     = r_q;
        w_iter_nxt  = r_iter;
        w_error_nxt = r_error;
        w_enter     = 1'b0;
        w_done_nxt  = 1'b0;
        if (set) begin
            w_q_nxt     = ({1'b0, d} < NUM_Q) ? d : IDLE;
            w_iter_nxt  = '0;
            w_error_nxt = 1'b0;
            w_enter     = 1'b1;
        end else if (w_expired) begin
            w_q_nxt     = IDLE;
            w_iter_nxt  = '0;
            w_error_nxt = 1'b1;
            w_enter     = 1'b1;
        end else if (run) begin
            if (!w_busy) begin
                if (start) begin
                    w_q_nxt     = FIRST;
                    w_iter_nxt  = '0;
                    w_error_nxt = 1'b0;
                    w_enter     = 1'b1;
                end
            end else if (stage_done) begin
                w_enter = 1'b1;
                // The final stage returns home even when it is also the loop end.
                if (r_q == LAST_Q) begin
                    w_q_nxt    = IDLE;
                    w_iter_nxt = '0;
                    w_done_nxt = 1'b1;
                end else if ((r_q == LOOP_L_Q) && (r_iter < ITER_MAX)) begin
                    w_q_nxt    = LOOP_F_Q;
                    w_iter_nxt = r_iter + ITER_LEN'(1);
                end else begin
                    w_q_nxt = r_q + STATE_LEN'(1);
                end
            end
        end
    end

    // State, loop counter, sticky error and the one-cycle entry/completion pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q           <= IDLE;
            r_iter        <= '0;
            r_stage_start <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_q           <= w_q_nxt;
            r_iter        <= w_iter_nxt;
            r_error       <= w_error_nxt;
            r_stage_start <= w_enter && (w_q_nxt != IDLE);
            r_done        <= w_done_nxt;
        end
    end

    assign q           = r_q;
    assign iter        = r_iter;
    assign busy        = w_busy;
    assign stage_start = r_stage_start;
    assign done        = r_done;
    assign error       = r_error;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer with NUM_STATES=6, loop 2..4 x3, TIMEOUT=16.
module tb_layer_sequencer;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic       start;
    logic       set;
    logic [2:0] d;
    logic       stage_done;
    logic [2:0] q;
    logic       stage_start;
    logic [1:0] iter;
    logic       busy;
    logic       done;
    logic       error;

    int n_checks;
    int n_fail;

    layer_sequencer #(
        .NUM_STATES (6),
        .LOOP_FIRST (2),
        .LOOP_LAST  (4),
        .NUM_ITER   (3),
        .TIMEOUT    (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .start       (start),
        .set         (set),
        .d           (d),
        .stage_done  (stage_done),
        .q           (q),
        .stage_start (stage_start),
        .iter        (iter),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [2:0] eq, input logic [1:0] eit,
                             input logic ess, input logic edone, input logic eerr);
        check({tag, ".q"}, 32'(q), 32'(eq));
        check({tag, ".iter"}, 32'(iter), 32'(eit));
        check({tag, ".stage_start"}, 32'(stage_start), 32'(ess));
        check({tag, ".done"}, 32'(done), 32'(edone));
        check({tag, ".busy"}, 32'(busy), 32'(eq != 3'd0));
        check({tag, ".error"}, 32'(error), 32'(eerr));
    endtask

    logic [2:0] seq_q  [11];
    logic [1:0] seq_it [11];

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        seq_q      = '{3'd2, 3'd3, 3'd4, 3'd2, 3'd3, 3'd4, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
        seq_it     = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
        rst_n      = 1'b0;
        run        = 1'b1;
        start      = 1'b1;
        set        = 1'b0;
        d          = 3'd0;
        stage_done = 1'b0;

        // 1: reset holds IDLE despite run/start
        step();
        step();
        check_all("reset", 3'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        check_all("start", 3'd1, 2'd0, 1'b1, 1'b0, 1'b0);
        start = 1'b0;
        step();
        check_all("hold1", 3'd1, 2'd0, 1'b0, 1'b0, 1'b0);

        // 2: full sequence with stage_done tied high
        stage_done = 1'b1;
        for (int i = 0; i < 11; i++) begin
            step();
            check_all($sformatf("seq%0d", i), seq_q[i], seq_it[i], seq_q[i] != 3'd0,
                      i == 10, 1'b0);
        end
        step();
        check_all("after_done", 3'd0, 2'd0, 1'b0, 1'b0, 1'b0);

        // 3: pause in state 3
        start      = 1'b1;
        stage_done = 1'b0;
        step();
        check_all("p_start", 3'd1, 2'd0, 1'b1, 1'b0, 1'b0);
        start      = 1'b0;
        stage_done = 1'b1;
        step();
        step();
        check_all("p_in3", 3'd3, 2'd0, 1'b1, 1'b0, 1'b0);
        run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_all($sformatf("pause%0d", i), 3'd3, 2'd0, 1'b0, 1'b0, 1'b0);
        end
        run = 1'b1;
        step();
        check_all("resume", 3'd4, 2'd0, 1'b1, 1'b0, 1'b0);

        // 4: set behaviour
        step();
        step();
        step();
        check_all("s_in4", 3'd4, 2'd1, 1'b1, 1'b0, 1'b0);
        stage_done = 1'b0;
        set        = 1'b1;
        d          = 3'd2;
        step();
        check_all("set2", 3'd2, 2'd0, 1'b1, 1'b0, 1'b0);
        d = 3'd7;
        step();
        check_all("set7", 3'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        d     = 3'd3;
        start = 1'b1;
        step();
        check_all("set_vs_start", 3'd3, 2'd0, 1'b1, 1'b0, 1'b0);
        start = 1'b0;
        step();
        check_all("set_same", 3'd3, 2'd0, 1'b1, 1'b0, 1'b0);

        // 5: watchdog expiry after 16 stalled cycles in state 2
        d = 3'd2;
        step();
        check_all("wd_in2", 3'd2, 2'd0, 1'b1, 1'b0, 1'b0);
        set = 1'b0;
        for (int i = 0; i < 15; i++) step();
        check_all("wd_15", 3'd2, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        check_all("wd_exp", 3'd0, 2'd0, 1'b0, 1'b0, 1'b1);
        step();
        check_all("wd_sticky", 3'd0, 2'd0, 1'b0, 1'b0, 1'b1);
        start = 1'b1;
        step();
        check_all("wd_clear", 3'd1, 2'd0, 1'b1, 1'b0, 1'b0);
        start      = 1'b0;
        stage_done = 1'b1;
        step();
        stage_done = 1'b0;
        for (int i = 0; i < 10; i++) step();
        run = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check_all("wd_paused", 3'd2, 2'd0, 1'b0, 1'b0, 1'b0);
        run = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check_all("wd_resume15", 3'd2, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        check_all("wd_exp2", 3'd0, 2'd0, 1'b0, 1'b0, 1'b1);

        // 6: asynchronous reset mid-run in state 3, iter 2
        start = 1'b1;
        step();
        start      = 1'b0;
        stage_done = 1'b1;
        for (int i = 0; i < 8; i++) step();
        check_all("ar_pre", 3'd3, 2'd2, 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("ar_async", 3'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        stage_done = 1'b0;
        step();
        check_all("ar_idle", 3'd0, 2'd0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
